// File: rtl/arbitro_temporizador.sv
// -----------------------------------------------------------------------------
// arbitro_temporizador
//   Two-requester round-robin arbiter that lends one shared 1-second timer
//   (Timer_1Segundo) to the winner for a requested number of seconds.
//   The owner holds gnt while its interval runs. fin pulses for one clock when
//   the interval completes.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   req0/req1    level requests, held until fin or withdrawn
//   seg0/seg1    seconds requested, sampled only at grant time
//   termino      one-clock pulse per elapsed second from the shared timer
//   timer_reset  high clears and holds the shared timer
//   gnt0/gnt1    owner of the shared timer (mutually exclusive)
//   fin0/fin1    one-clock completion pulse
//   ocupado      arbiter not idle
//   restante     seconds still to elapse for the current owner (0 when idle)
// -----------------------------------------------------------------------------
module arbitro_temporizador #(
  parameter int ANCHO = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [ANCHO-1:0] seg0,
  input  logic             req1,
  input  logic [ANCHO-1:0] seg1,
  input  logic             termino,
  output logic             timer_reset,
  output logic             gnt0,
  output logic             gnt1,
  output logic             fin0,
  output logic             fin1,
  output logic             ocupado,
  output logic [ANCHO-1:0] restante
);

  typedef enum logic [1:0] {LIBRE, CARGA, CONTANDO, FIN} estado_t;

  estado_t          state_q, state_d;
  logic             owner_q, owner_d;
  logic             ultimo_q, ultimo_d;
  logic [ANCHO-1:0] cnt_q, cnt_d;
  logic             timer_reset_q, timer_reset_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             fin0_q, fin0_d;
  logic             fin1_q, fin1_d;
  logic             ocupado_q, ocupado_d;
  logic [ANCHO-1:0] restante_q, restante_d;

  logic             ganador;
  logic [ANCHO-1:0] seg_ganador;
  logic             owner_req;
  logic             activo_d;

  always_comb begin
    // Round-robin: on contention the requester that was not served last wins.
    if (req0 && req1) ganador = ~ultimo_q;
    else              ganador = req1;
    seg_ganador = ganador ? seg1 : seg0;
    owner_req   = owner_q ? req1 : req0;

    state_d  = state_q;
    owner_d  = owner_q;
    ultimo_d = ultimo_q;
    cnt_d    = cnt_q;

    case (state_q)
      LIBRE: begin
        if (req0 || req1) begin
          owner_d = ganador;
          cnt_d   = seg_ganador;
          if (seg_ganador == '0) begin
            // Zero-length interval completes immediately.
            state_d  = FIN;
            ultimo_d = ganador;
          end else begin
            state_d = CARGA;
          end
        end
      end
      CARGA: begin
        if (!owner_req) begin
          state_d  = LIBRE;
          ultimo_d = owner_q;
          cnt_d    = '0;
        end else begin
          state_d = CONTANDO;
        end
      end
      CONTANDO: begin
        // Withdrawal takes priority over a coincident termino.
        if (!owner_req) begin
          state_d  = LIBRE;
          ultimo_d = owner_q;
          cnt_d    = '0;
        end else if (termino) begin
          if (cnt_q <= ANCHO'(1)) begin
            state_d  = FIN;
            ultimo_d = owner_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q - ANCHO'(1);
          end
        end
      end
      FIN: begin
        state_d = LIBRE;
        cnt_d   = '0;
      end
      default: begin
        state_d = LIBRE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered: they are decoded from the next state so they
    // line up with the state register.
    activo_d      = (state_d == CARGA) || (state_d == CONTANDO);
    timer_reset_d = (state_d != CONTANDO);
    ocupado_d     = (state_d != LIBRE);
    gnt0_d        = activo_d && !owner_d;
    gnt1_d        = activo_d && owner_d;
    fin0_d        = (state_d == FIN) && !owner_d;
    fin1_d        = (state_d == FIN) && owner_d;
    restante_d    = activo_d ? cnt_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LIBRE;
      owner_q       <= 1'b0;
      ultimo_q      <= 1'b1;
      cnt_q         <= '0;
      timer_reset_q <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      fin0_q        <= 1'b0;
      fin1_q        <= 1'b0;
      ocupado_q     <= 1'b0;
      restante_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ultimo_q      <= ultimo_d;
      cnt_q         <= cnt_d;
      timer_reset_q <= timer_reset_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      fin0_q        <= fin0_d;
      fin1_q        <= fin1_d;
      ocupado_q     <= ocupado_d;
      restante_q    <= restante_d;
    end
  end

  assign timer_reset = timer_reset_q;
  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign fin0        = fin0_q;
  assign fin1        = fin1_q;
  assign ocupado     = ocupado_q;
  assign restante    = restante_q;

endmodule

// File: tb/tb_arbitro_temporizador.sv
// -----------------------------------------------------------------------------
// tb_arbitro_temporizador
//   Directed bench for arbitro_temporizador. A per-cycle vector table (with
//   termino driven directly) covers arbitration, withdrawal and zero-length
//   requests; hand-written sequences use a model of Timer_1Segundo (termino
//   every 10 clocks while timer_reset is low) for the long intervals,
//   alternation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_arbitro_temporizador;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [5:0] seg0, seg1;
  logic       termino;
  logic       timer_reset, gnt0, gnt1, fin0, fin1, ocupado;
  logic [5:0] restante;

  logic       use_model;
  logic       tab_t;
  logic [3:0] tcnt;
  logic       mod_termino;

  int total = 0;
  int bad   = 0;

  arbitro_temporizador #(.ANCHO(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .seg0        (seg0),
    .req1        (req1),
    .seg1        (seg1),
    .termino     (termino),
    .timer_reset (timer_reset),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .fin0        (fin0),
    .fin1        (fin1),
    .ocupado     (ocupado),
    .restante    (restante)
  );

  always #5 clk = ~clk;

  // Timer_1Segundo model: held at zero while timer_reset is high.
  always @(posedge clk) begin
    if (timer_reset)    tcnt <= 4'd0;
    else if (tcnt == 9) tcnt <= 4'd0;
    else                tcnt <= tcnt + 4'd1;
  end
  assign mod_termino = !timer_reset && (tcnt == 4'd9);
  assign termino     = use_model ? mod_termino : tab_t;

  typedef struct packed {
    logic       r0;
    logic [5:0] s0;
    logic       r1;
    logic [5:0] s1;
    logic       t;
    logic [5:0] flags;  // {gnt0, gnt1, fin0, fin1, timer_reset, ocupado}
    logic [5:0] rest;
  } vec_t;

  vec_t tab [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {gnt0, gnt1, fin0, fin1, timer_reset, ocupado, restante};
  endfunction

  int fin_cnt, fin_at, both, act_cnt, k;
  int order[$];

  initial begin
    //           r0    s0    r1    s1    t     g0g1f0f1trOc  rest
    tab[0]  = '{1'b1, 6'd2, 1'b0, 6'd0, 1'b0, 6'b100011, 6'd2};
    tab[1]  = '{1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'b100001, 6'd2};
    tab[2]  = '{1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 6'b100001, 6'd2};
    tab[3]  = '{1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'b100001, 6'd1};
    tab[4]  = '{1'b1, 6'd5, 1'b0, 6'd0, 1'b1, 6'b001011, 6'd0};
    tab[5]  = '{1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'b000010, 6'd0};
    tab[6]  = '{1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'b000111, 6'd0};
    tab[7]  = '{1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'b000010, 6'd0};
    tab[8]  = '{1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'b100011, 6'd1};
    tab[9]  = '{1'b0, 6'd1, 1'b1, 6'd3, 1'b0, 6'b000010, 6'd0};
    tab[10] = '{1'b1, 6'd1, 1'b1, 6'd3, 1'b0, 6'b010011, 6'd3};
    tab[11] = '{1'b1, 6'd1, 1'b1, 6'd9, 1'b1, 6'b010001, 6'd3};
    tab[12] = '{1'b1, 6'd1, 1'b1, 6'd9, 1'b1, 6'b010001, 6'd2};
    tab[13] = '{1'b1, 6'd4, 1'b0, 6'd9, 1'b0, 6'b000010, 6'd0};
    tab[14] = '{1'b1, 6'd4, 1'b0, 6'd0, 1'b0, 6'b100011, 6'd4};
    tab[15] = '{1'b0, 6'd4, 1'b0, 6'd0, 1'b0, 6'b000010, 6'd0};
    tab[16] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'b000010, 6'd0};
    tab[17] = '{1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 6'b000111, 6'd0};
    tab[18] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'b000010, 6'd0};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; seg0 = '0; seg1 = '0;
    tab_t = 1'b0; use_model = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(outs()), 32'({6'b000010, 6'd0}));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(outs()), 32'({6'b000010, 6'd0}));

    // Per-cycle vector table.
    for (int i = 0; i < 19; i++) begin
      req0 = tab[i].r0; seg0 = tab[i].s0;
      req1 = tab[i].r1; seg1 = tab[i].s1;
      tab_t = tab[i].t;
      @(negedge clk);
      $display("vec %0d: outs=%03h exp=%03h", i, outs(), {tab[i].flags, tab[i].rest});
      chk($sformatf("vec%0d", i), 32'(outs()), 32'({tab[i].flags, tab[i].rest}));
    end
    tab_t = 1'b0;
    use_model = 1'b1;

    // Lone requester, 3 seconds with the timer model.
    req0 = 1'b1; seg0 = 6'd3;
    @(negedge clk);
    chk("s1_grant", 32'(gnt0), 32'd1);
    chk("s1_rest0", 32'(restante), 32'd3);
    fin_cnt = 0; fin_at = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5)  chk("s1_timer_run", 32'(timer_reset), 32'd0);
      if (i == 10) chk("s1_rest_10", 32'(restante), 32'd3);
      if (i == 11) chk("s1_rest_11", 32'(restante), 32'd2);
      if (i == 21) chk("s1_rest_21", 32'(restante), 32'd1);
      if (fin0) begin
        fin_cnt++;
        if (fin_at < 0) fin_at = i;
        chk("s1_gnt_at_fin", 32'(gnt0), 32'd0);
        req0 = 1'b0;
      end
    end
    $display("s1: fin0 at +%0d, pulses=%0d", fin_at, fin_cnt);
    chk("s1_fin_time", 32'(fin_at), 32'd31);
    chk("s1_fin_pulses", 32'(fin_cnt), 32'd1);

    // Contention from reset, then continuous alternation.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; seg0 = 6'd2; req1 = 1'b1; seg1 = 6'd1;
    @(negedge clk);
    chk("s2_first_gnt0", 32'({gnt0, gnt1}), 32'b10);
    both = 0;
    order.delete();
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if (fin0) begin order.push_back(0); seg0 = 6'd1; end
      if (fin1) order.push_back(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    $display("s2: fins=%0d both_gnt=%0d", order.size(), both);
    chk("s2_no_double_gnt", 32'(both), 32'd0);
    chk("s2_fin_count_ge4", 32'(order.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      k = (i < order.size()) ? order[i] : -1;
      chk($sformatf("s2_order%0d", i), 32'(k), 32'(i % 2));
    end

    // Withdraw-free interval aborted by asynchronous reset.
    req0 = 1'b1; seg0 = 6'd4;
    @(negedge clk);
    chk("s3_grant", 32'(gnt0), 32'd1);
    repeat (5) @(negedge clk);
    chk("s3_rest_before", 32'(restante), 32'd4);
    reset = 1'b1;
    #1;
    $display("s3: outs during async reset=%03h", outs());
    chk("s3_async_reset", 32'(outs()), 32'({6'b000010, 6'd0}));
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0;
    act_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fin0 || fin1 || gnt0 || gnt1) act_cnt++;
    end
    chk("s3_no_fin_after", 32'(act_cnt), 32'd0);
    req1 = 1'b1; seg1 = 6'd0;
    @(negedge clk);
    chk("s3_resume_fin1", 32'({fin1, gnt1, timer_reset}), 32'b101);
    req1 = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
